// File: rtl/vdma_video_pkg.sv
// Shared definitions for the VDMA video output path: default raster timing,
// stream FIFO entry layout and lock state encoding.
package vdma_video_pkg;

    localparam int DSIZE_DEF    = 24;
    localparam int H_ACTIVE_DEF = 1920;
    localparam int H_FP_DEF     = 88;
    localparam int H_SYNC_DEF   = 44;
    localparam int H_BP_DEF     = 148;
    localparam int V_ACTIVE_DEF = 1080;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 36;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 16;

    localparam int TUSER_BIT_DEF = DSIZE_DEF;
    localparam int TLAST_BIT_DEF = DSIZE_DEF + 1;

    // FIFO entry is {tlast, tuser, tdata}
    function automatic int tuser_bit(input int dsize);
        return dsize;
    endfunction

    function automatic int tlast_bit(input int dsize);
        return dsize + 1;
    endfunction

    localparam logic SEARCH = 1'b0;
    localparam logic RUN    = 1'b1;

    typedef enum logic {
        ST_SEARCH = SEARCH,
        ST_RUN    = RUN
    } state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO between the stream sink and the raster pop side.
// Flush has priority over push and pop; push on full is taken only with a pop.
module axis_sync_fifo #(
    parameter int DSIZE = 26,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DSIZE-1:0]         din,
    output logic [DSIZE-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = AW + 1;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FCW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + FCW'(1);
            else if (!do_push && do_pop)
                count <= count - FCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axis_to_native.sv
// AXI4-Stream video sink driving native parallel video from a free-running
// raster generator; locks to the stream at a frame boundary.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_SEARCH | drop beats until SOF, buffer from SOF, wait for frame end
//   ST_RUN    | pop one entry per active pixel, check SOF/EOL alignment
module axis_to_native
    import vdma_video_pkg::*;
#(
    parameter int DSIZE      = DSIZE_DEF,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DSIZE-1:0] axi_tdata,
    input  logic             axi_tvalid,
    output logic             axi_tready,
    input  logic             axi_tuser,
    input  logic             axi_tlast,
    output logic             vsync,
    output logic             hsync,
    output logic             de,
    output logic [DSIZE-1:0] odata,
    output logic             locked,
    output logic             sync_err
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int EW        = DSIZE + 2;
    localparam int FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam int TUSER_BIT = tuser_bit(DSIZE);
    localparam int TLAST_BIT = tlast_bit(DSIZE);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_EOL  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    state_t           state;
    logic             wr_gate;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;

    logic [EW-1:0]    fifo_din;
    logic [EW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [FCW-1:0]   fifo_count;

    logic act;
    logic frame_end;
    logic pop_req;
    logic bad_sof;
    logic bad_eol;
    logic pix_err;

    assign act       = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
    assign pop_req   = (state == ST_RUN) && act && enable;

    assign bad_sof = fifo_dout[TUSER_BIT] != ((hcnt == '0) && (vcnt == '0));
    assign bad_eol = fifo_dout[TLAST_BIT] != (hcnt == H_EOL);
    assign pix_err = pop_req && (fifo_empty || bad_sof || bad_eol);
    assign fifo_pop = pop_req && !fifo_empty;

    // Before SOF has been seen every beat is taken and thrown away.
    assign axi_tready = (state == ST_RUN || wr_gate) ? !fifo_full : 1'b1;
    assign fifo_push  = axi_tvalid && axi_tready && (wr_gate || axi_tuser);
    assign fifo_din   = {axi_tlast, axi_tuser, axi_tdata};

    axis_sync_fifo #(
        .DSIZE (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (pix_err),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (enable) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SEARCH;
            wr_gate  <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
            de       <= 1'b0;
            odata    <= '0;
        end else begin
            sync_err <= pix_err;
            case (state)
                ST_SEARCH: begin
                    if (fifo_push)
                        wr_gate <= 1'b1;
                    if (frame_end && enable && fifo_count >= FCW'(2)) begin
                        state  <= ST_RUN;
                        locked <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pix_err) begin
                        state   <= ST_SEARCH;
                        locked  <= 1'b0;
                        wr_gate <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_SEARCH;
                    locked  <= 1'b0;
                    wr_gate <= 1'b0;
                end
            endcase
            // A paused raster holds every video output, including a high de.
            if (enable) begin
                hsync <= (hcnt >= HS_BEG) && (hcnt < HS_END);
                vsync <= (vcnt >= VS_BEG) && (vcnt < VS_END);
                de    <= act && (state == ST_RUN);
                odata <= (pop_req && !pix_err) ? fifo_dout[DSIZE-1:0] : '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_to_native.sv
// Directed bench for axis_to_native on a 7x5 raster (4x2 active), FIFO depth 8.
module tb_axis_to_native;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic [DW-1:0] axi_tdata = '0;
    logic          axi_tvalid = 1'b0;
    logic          axi_tready;
    logic          axi_tuser = 1'b0;
    logic          axi_tlast = 1'b0;
    logic          vsync;
    logic          hsync;
    logic          de;
    logic [DW-1:0] odata;
    logic          locked;
    logic          sync_err;

    always #5 clock = ~clock;

    axis_to_native #(
        .DSIZE      (DW),
        .H_ACTIVE   (4),
        .H_FP       (1),
        .H_SYNC     (1),
        .H_BP       (1),
        .V_ACTIVE   (2),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .FIFO_DEPTH (8)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (enable),
        .axi_tdata  (axi_tdata),
        .axi_tvalid (axi_tvalid),
        .axi_tready (axi_tready),
        .axi_tuser  (axi_tuser),
        .axi_tlast  (axi_tlast),
        .vsync      (vsync),
        .hsync      (hsync),
        .de         (de),
        .odata      (odata),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    int total = 0;
    int bad = 0;

    logic [DW+1:0] q[$];
    logic [DW-1:0] got[$];
    int            pos = 0;
    logic          exp_hs = 1'b0;
    logic          exp_vs = 1'b0;
    logic          exp_act = 1'b0;
    int            n_err = 0;
    logic [DW-1:0] err_data = '0;
    logic          saw_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input logic last, input logic user, input logic [DW-1:0] data);
        q.push_back({last, user, data});
    endtask

    // One clock: offer the queue head, track the handshake, advance the raster model, check.
    task automatic tick();
        logic hs;
        logic en_edge;
        if (q.size() != 0) begin
            axi_tvalid = 1'b1;
            {axi_tlast, axi_tuser, axi_tdata} = q[0];
        end else begin
            axi_tvalid = 1'b0;
            axi_tlast  = 1'b0;
            axi_tuser  = 1'b0;
            axi_tdata  = '0;
        end
        @(negedge clock);
        hs = axi_tvalid && axi_tready;
        if (axi_tvalid && !axi_tready)
            saw_stall = 1'b1;
        en_edge = enable && rst_n;
        @(posedge clock);
        #1;
        if (hs)
            void'(q.pop_front());
        if (!rst_n) begin
            exp_hs  = 1'b0;
            exp_vs  = 1'b0;
            exp_act = 1'b0;
        end else if (en_edge) begin
            exp_hs  = (pos % 7) == 5;
            exp_vs  = (pos / 7) == 3;
            exp_act = ((pos % 7) < 4) && ((pos / 7) < 2);
            pos     = (pos + 1) % 35;
        end
        chk("hsync", hsync, exp_hs);
        chk("vsync", vsync, exp_vs);
        if (de === 1'b1) begin
            chk("de_in_active", 1'b1, exp_act);
            got.push_back(odata);
        end
        if (sync_err === 1'b1) begin
            n_err++;
            err_data = odata;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        q.delete();
        repeat (3) tick();
        got.delete();
        n_err = 0;
        saw_stall = 1'b0;
        pos = 0;
        rst_n = 1'b1;
    endtask

    task automatic add_frame(input int base, input int bad_eol_at);
        for (int i = 0; i < 8; i++) begin
            logic last;
            last = (bad_eol_at >= 0) ? (i == bad_eol_at || i == 7) : (i == 3 || i == 7);
            add_beat(last, i == 0, DW'(base + i));
        end
    endtask

    task automatic chk_pixels(input string tag, input logic [DW-1:0] exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (i < got.size()) ? got[i] : 'hff, exp[i]);
    endtask

    initial begin
        logic [DW-1:0] expv[$];

        // Reset state
        rst_n = 1'b0;
        repeat (10) tick();
        chk("rst_vsync", vsync, 0);
        chk("rst_hsync", hsync, 0);
        chk("rst_de", de, 0);
        chk("rst_odata", odata, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_tready", axi_tready, 1);

        // Lock and play
        do_reset();
        add_frame(1, -1);
        repeat (34) tick();
        chk("lp_prelock", locked, 0);
        tick();
        chk("lp_locked", locked, 1);
        repeat (35) tick();
        expv = '{1, 2, 3, 4, 5, 6, 7, 8};
        chk_pixels("lp_pix", expv);
        chk("lp_err_cnt", n_err, 0);
        chk("lp_locked_end", locked, 1);

        // Junk before SOF
        do_reset();
        for (int i = 0; i < 3; i++)
            add_beat(1'b0, 1'b0, DW'(8'ha0 + i));
        add_frame(1, -1);
        repeat (3) tick();
        chk("junk_drained", q.size(), 8);
        repeat (67) tick();
        chk_pixels("junk_pix", expv);
        chk("junk_err_cnt", n_err, 0);
        chk("junk_locked", locked, 1);

        // Underflow at line 2 pixel 2
        do_reset();
        for (int i = 0; i < 5; i++)
            add_beat(i == 3, i == 0, DW'(i + 1));
        repeat (70) tick();
        expv = '{1, 2, 3, 4, 5, 0};
        chk_pixels("uf_pix", expv);
        chk("uf_err_cnt", n_err, 1);
        chk("uf_err_data", err_data, 0);
        chk("uf_locked", locked, 0);

        // EOL on pixel 3, then a good frame relocks
        do_reset();
        add_frame(1, 2);
        repeat (40) tick();
        chk("mis_err_cnt", n_err, 1);
        chk("mis_unlocked", locked, 0);
        add_frame(9, -1);
        repeat (64) tick();
        expv = '{1, 2, 0, 9, 10, 11, 12, 13, 14, 15, 16};
        chk_pixels("mis_pix", expv);
        chk("mis_err_total", n_err, 1);
        chk("mis_relocked", locked, 1);

        // Back-pressure with enable toggling every clock
        do_reset();
        add_frame(1, -1);
        add_frame(9, -1);
        for (int i = 0; i < 210; i++) begin
            enable = (i % 2) == 0;
            tick();
        end
        enable = 1'b1;
        chk("bp_stall_seen", saw_stall, 1);
        expv.delete();
        for (int i = 0; i < 32; i++)
            expv.push_back(DW'(i / 2 + 1));
        chk_pixels("bp_pix", expv);
        chk("bp_err_cnt", n_err, 0);
        chk("bp_locked", locked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
